// File: rtl/stonyman_emulator.sv
`timescale 1ns/1ps
// stonyman_emulator: behavioural stand-in for a Stonyman image sensor.
// Strobe-driven pointer and 8-entry register file, inphi edge counter, and an
// ADC responder that returns rowsel+colsel after a fixed conversion latency.
// The register-file entry 5 port is named config_reg because "config" is a
// reserved word.
module stonyman_emulator #(
    parameter int unsigned ADC_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       resp,
    input  logic       incp,
    input  logic       resv,
    input  logic       incv,
    input  logic       inphi,
    input  logic       adc_capture_start,
    output logic       adc_capture_done,
    output logic [9:0] adc_data,
    output logic [2:0] ptr_value,
    output logic [7:0] colsel,
    output logic [7:0] rowsel,
    output logic [7:0] vsw,
    output logic [7:0] hsw,
    output logic [7:0] vref,
    output logic [7:0] config_reg,
    output logic [7:0] nbias,
    output logic [7:0] aobias,
    output logic [7:0] inphi_count,
    output logic       protocol_error
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t          state;
    state_t          state_next;

    logic [5:0]      strobe_in;
    logic [5:0]      strobe_q;
    logic [5:0]      edges;
    logic            live;

    logic            e_resp;
    logic            e_incp;
    logic            e_resv;
    logic            e_incv;
    logic            e_inphi;
    logic            e_start;

    logic [2:0]      ptr;
    logic [7:0][7:0] regs;
    logic [3:0]      cnt;
    logic [7:0]      row_snap;
    logic [7:0]      col_snap;
    logic            err;
    logic [7:0]      phi_cnt;

    logic            strobe_clash;
    logic            start_ignored;

    assign strobe_in = {adc_capture_start, inphi, incv, resv, incp, resp};

    // The first clock after reset only primes the samples, so an input held
    // high across reset release does not register as a rising edge.
    assign edges = live ? (strobe_in & ~strobe_q) : '0;

    assign e_resp  = edges[0];
    assign e_incp  = edges[1];
    assign e_resv  = edges[2];
    assign e_incv  = edges[3];
    assign e_inphi = edges[4];
    assign e_start = edges[5];

    assign strobe_clash  = $countones(edges[3:0]) > 1;
    assign start_ignored = e_start && (state != IDLE);

    // Edge-detect samples of every strobe input plus the priming flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q <= '0;
            live     <= 1'b0;
        end else begin
            strobe_q <= strobe_in;
            live     <= 1'b1;
        end
    end

    // Pointer and register file; one strobe action per cycle, resp > incp > resv > incv.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            regs <= '0;
        end else if (e_resp) begin
            ptr <= '0;
        end else if (e_incp) begin
            ptr <= ptr + 3'd1;
        end else if (e_resv) begin
            regs[ptr] <= '0;
        end else if (e_incv) begin
            regs[ptr] <= regs[ptr] + 8'd1;
        end
    end

    // Sticky protocol error: simultaneous strobes or a start while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (strobe_clash || start_ignored) begin
            err <= 1'b1;
        end
    end

    // Wrapping count of inphi rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_cnt <= '0;
        end else if (e_inphi) begin
            phi_cnt <= phi_cnt + 8'd1;
        end
    end

    // ADC FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ADC FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (e_start) state_next = CONVERT;
            CONVERT: if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ADC FSM outputs.
    always_comb begin
        adc_capture_done = (state == DONE);
    end

    // ADC datapath: snapshot on start, count down, latch the sample entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            row_snap <= '0;
            col_snap <= '0;
            adc_data <= '0;
        end else begin
            if (state == IDLE && e_start) begin
                cnt      <= 4'(ADC_LATENCY);
                row_snap <= regs[1];
                col_snap <= regs[0];
            end
            if (state == CONVERT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == CONVERT && state_next == DONE) begin
                adc_data <= {2'b00, row_snap} + {2'b00, col_snap};
            end
        end
    end

    assign ptr_value      = ptr;
    assign colsel         = regs[0];
    assign rowsel         = regs[1];
    assign vsw            = regs[2];
    assign hsw            = regs[3];
    assign vref           = regs[4];
    assign config_reg     = regs[5];
    assign nbias          = regs[6];
    assign aobias         = regs[7];
    assign inphi_count    = phi_cnt;
    assign protocol_error = err;

endmodule

// File: tb/tb_stonyman_emulator.sv
`timescale 1ns/1ps
// Directed bench for stonyman_emulator: a model of pointer/registers/error flag,
// and a queue of expected ADC samples checked by a done-pulse monitor.
module tb_stonyman_emulator;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       resp, incp, resv, incv, inphi, adc_capture_start;
    logic       adc_capture_done;
    logic [9:0] adc_data;
    logic [2:0] ptr_value;
    logic [7:0] colsel, rowsel, vsw, hsw, vref, config_reg, nbias, aobias;
    logic [7:0] inphi_count;
    logic       protocol_error;

    stonyman_emulator #(.ADC_LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .resp              (resp),
        .incp              (incp),
        .resv              (resv),
        .incv              (incv),
        .inphi             (inphi),
        .adc_capture_start (adc_capture_start),
        .adc_capture_done  (adc_capture_done),
        .adc_data          (adc_data),
        .ptr_value         (ptr_value),
        .colsel            (colsel),
        .rowsel            (rowsel),
        .vsw               (vsw),
        .hsw               (hsw),
        .vref              (vref),
        .config_reg        (config_reg),
        .nbias             (nbias),
        .aobias            (aobias),
        .inphi_count       (inphi_count),
        .protocol_error    (protocol_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [9:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [2:0]      m_ptr;
    logic [7:0][7:0] m_regs;
    logic            m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] regs_now();
        return {aobias, nbias, config_reg, vref, hsw, vsw, rowsel, colsel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ptr"}, ptr_value, m_ptr);
        chk({tag, "_regs"}, regs_now(), m_regs);
        chk({tag, "_err"}, protocol_error, m_err);
    endtask

    // Pulse the selected strobes {incv,resv,incp,resp} for one cycle and update the model.
    task automatic strobe(input logic [3:0] m);
        {incv, resv, incp, resp} = m;
        if (m[0])      m_ptr = 3'd0;
        else if (m[1]) m_ptr = m_ptr + 3'd1;
        else if (m[2]) m_regs[m_ptr] = 8'd0;
        else if (m[3]) m_regs[m_ptr] = m_regs[m_ptr] + 8'd1;
        if ((32'(m[0]) + 32'(m[1]) + 32'(m[2]) + 32'(m[3])) > 1) m_err = 1'b1;
        tick();
        {incv, resv, incp, resp} = 4'b0000;
        tick();
    endtask

    task automatic strobe_n(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) strobe(m);
    endtask

    task automatic phi_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            inphi = 1'b1;
            tick();
            inphi = 1'b0;
            tick();
        end
    endtask

    // Assert reset asynchronously, check reset values while held, then release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ptr", ptr_value, 0);
        chk("rst_regs", regs_now(), 0);
        chk("rst_inphi_count", inphi_count, 0);
        chk("rst_protocol_error", protocol_error, 0);
        chk("rst_done", adc_capture_done, 0);
        chk("rst_adc_data", adc_data, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_ptr  = '0;
        m_regs = '0;
        m_err  = 1'b0;
        tick();
    endtask

    task automatic start_conv();
        exp_t e;
        e.data = {2'b00, m_regs[1]} + {2'b00, m_regs[0]};
        e.cyc  = cyc + LAT + 1;
        exp_q.push_back(e);
        adc_capture_start = 1'b1;
        tick();
        adc_capture_start = 1'b0;
    endtask

    // Every done pulse must match the next queued sample, in value and cycle.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (adc_capture_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("adc_spurious_done", adc_capture_done, 0);
            end else begin
                e = exp_q.pop_front();
                chk("adc_data", adc_data, e.data);
                chk("adc_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {resp, incp, resv, incv, inphi, adc_capture_start} = '0;
        m_ptr = '0; m_regs = '0; m_err = 1'b0;
        tick();
        do_reset();

        // resp, incp x2, resv, incv x41
        strobe(4'b0001);
        strobe_n(4'b0010, 2);
        strobe(4'b0100);
        strobe_n(4'b1000, 41);
        check_state("seq1");
        chk("seq1_ptr_const", ptr_value, 2);
        chk("seq1_vsw_const", vsw, 41);

        // pointer wrap and register wrap
        strobe(4'b0001);
        strobe_n(4'b0010, 9);
        chk("ptr_wrap", ptr_value, 1);
        strobe(4'b0001);
        strobe_n(4'b0010, 4);
        strobe_n(4'b1000, 255);
        chk("vref_255", vref, 255);
        strobe(4'b1000);
        chk("vref_wrap", vref, 0);
        check_state("wrap");

        // colsel=200, rowsel=100, then a conversion with a write mid-conversion
        strobe(4'b0001);
        strobe_n(4'b1000, 200);
        strobe(4'b0010);
        strobe_n(4'b1000, 100);
        check_state("adc_setup");
        start_conv();
        strobe(4'b1000);
        repeat (4) tick();
        chk("adc_hold_300", adc_data, 300);
        chk("rowsel_mid_conv", rowsel, 101);
        chk("adc_q_after_first", exp_q.size(), 0);
        chk("adc_first_err", protocol_error, 0);

        // second start during CONVERT is ignored and flagged
        start_conv();
        tick();
        adc_capture_start = 1'b1;
        tick();
        adc_capture_start = 1'b0;
        m_err = 1'b1;
        repeat (5) tick();
        chk("adc_q_after_double", exp_q.size(), 0);
        check_state("double_start");

        // priority on simultaneous strobes
        do_reset();
        strobe_n(4'b0010, 3);
        strobe(4'b1000);
        chk("hsw_pre", hsw, 1);
        strobe(4'b1001);
        chk("clash_ptr", ptr_value, 0);
        chk("clash_hsw", hsw, 1);
        chk("clash_err", protocol_error, 1);
        check_state("clash1");
        strobe(4'b1110);
        check_state("clash2");
        strobe(4'b1000);
        strobe(4'b1100);
        check_state("clash3");

        // reset during CONVERT: no done pulse may follow
        do_reset();
        strobe(4'b1000);
        start_conv();
        void'(exp_q.pop_back());
        do_reset();
        repeat (8) tick();
        check_state("abort");

        // inputs held high across reset release produce no edge
        incp = 1'b1;
        adc_capture_start = 1'b1;
        do_reset();
        repeat (3) tick();
        chk("held_ptr", ptr_value, 0);
        incp = 1'b0;
        adc_capture_start = 1'b0;
        tick();
        strobe(4'b0010);
        chk("held_then_edge_ptr", ptr_value, 1);
        check_state("held");

        // inphi counting with wrap
        phi_pulses(5);
        chk("inphi_5", inphi_count, 5);
        phi_pulses(300);
        chk("inphi_305", inphi_count, 49);

        repeat (5) tick();
        chk("adc_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stonyman_emulator.md
STONYMAN_EMULATOR -- requirements
Module: stonyman_emulator

Interface
REQ-001 Parameter ADC_LATENCY, default 2, is the number of cycles spent in CONVERT (legal range 1..15).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 resp  input  1  pointer reset strobe from the controller.
REQ-005 incp  input  1  pointer increment strobe.
REQ-006 resv  input  1  reset of the register at the current pointer.
REQ-007 incv  input  1  increment of the register at the current pointer.
REQ-008 inphi  input  1  amplifier phase strobe; rising edges are counted only.
REQ-009 adc_capture_start  input  1  conversion request.
REQ-010 adc_capture_done  output  1  one-cycle conversion-complete pulse.
REQ-011 adc_data  output  10  synthetic pixel sample, valid while adc_capture_done is high.
REQ-012 ptr_value  output  3  current register pointer.
REQ-013 colsel, rowsel, vsw, hsw, vref, config, nbias, aobias  output  8 each  register file entries 0..7.
REQ-014 inphi_count  output  8  count of inphi rising edges since reset, wrapping.
REQ-015 protocol_error  output  1  sticky error flag, cleared only by reset.

Function
REQ-016 The block registers every strobe input once; a rising edge is "previous sample 0, current input 1", and only rising edges act.
REQ-017 resp edge sets ptr_value to 0 in the following cycle.
REQ-018 incp edge sets ptr_value to ptr_value+1 mod 8 (7 wraps to 0).
REQ-019 resv edge sets the register addressed by ptr_value to 0.
REQ-020 incv edge sets the addressed register to its value+1 mod 256 (255 wraps to 0).
REQ-021 When several of resp/incp/resv/incv edges occur in the same cycle, only the highest-priority one acts: resp > incp > resv > incv.
REQ-022 Any such simultaneous strobe edge also sets protocol_error.
REQ-023 The ADC responder FSM has three states: IDLE, CONVERT, DONE.
REQ-024 IDLE->CONVERT on an adc_capture_start rising edge; on that transition the FSM snapshots rowsel/colsel and loads its counter with ADC_LATENCY.
REQ-025 CONVERT decrements the counter each cycle and goes to DONE when the counter reaches 1.
REQ-026 DONE drives adc_capture_done=1 and adc_data = {2'b00, rowsel_snap} + {2'b00, colsel_snap} for exactly one cycle, then returns to IDLE.
REQ-027 Latency: start edge detected in cycle N -> adc_capture_done high in cycle N+ADC_LATENCY+1.
REQ-028 An adc_capture_start edge while in CONVERT or DONE is ignored and sets protocol_error.
REQ-029 Register writes during CONVERT take effect immediately but do not alter the pending sample.
REQ-030 adc_data holds its last value outside DONE.

Reset
REQ-031 Asynchronous reset sets ptr_value=0, all eight registers=0, inphi_count=0, protocol_error=0, adc_capture_done=0, adc_data=0, FSM=IDLE, and all edge-detect samples=0.
REQ-032 Reset asserted mid-conversion aborts the conversion; no adc_capture_done pulse follows release.
REQ-033 An input held high across reset release produces no edge until it falls and rises again.

Verification
REQ-034 Sequence resp, incp x2, resv, incv x41 -> ptr_value=2, vsw=41, all other registers 0.
REQ-035 incp x9 from ptr 0 -> ptr_value=1; incv x256 at ptr 4 -> vref=0.
REQ-036 rowsel=100, colsel=200, start pulse at cycle N, ADC_LATENCY=2 -> adc_capture_done high only in cycle N+3, adc_data=300.
REQ-037 resp and incv rise in the same cycle with ptr=3 -> ptr_value=0, hsw unchanged, protocol_error=1.
REQ-038 Second start during CONVERT -> exactly one done pulse, protocol_error=1; reset during CONVERT -> no done pulse, all outputs at reset values.
REQ-039 Five inphi pulses, then a 300-pulse run -> inphi_count=5, then 49 (305 mod 256).
